mem_bus_ctrl: RTL

//  Load/store bus controller, directly downstream of the core datapath's memory port.
//  - Takes the single-cycle address/data/enable request from the datapath.
//  - Decodes it to data RAM (sync read, 1-cycle latency) or the UART MMIO window.
//  - Sequences wait states and returns read data; stalls the core until each access completes.

---
 rtl/mem_bus_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - load/store bus controller: data RAM and UART MMIO decode, wait states, stall
// Optional feature macro: MMIO_TIMEOUT_EN (bounds the wait for uart_tx_ready to TIMEOUT cycles).
module mem_bus_ctrl #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_we,
  input  logic              req_re,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_RD  = 2'd1,
    UART_TX = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] rdata_q;
  logic [31:0] rdata_nxt;
  logic        load_tx;
  logic        set_err;
  logic        tx_timeout;

  // Address decode. A store wins when both strobes are high.
  logic        req_ok;
  logic        is_wr;
  logic        is_rd;
  logic        hit_ram;
  logic        hit_uart;
  logic [31:0] uart_off;
  logic [1:0]  uart_reg;

  // Requests are ignored while reset is asserted so every output reads 0.
  assign req_ok   = rst & (req_we | req_re);
  assign is_wr    = req_we;
  assign is_rd    = req_re & ~req_we;
  assign hit_ram  = (req_addr[31:RAM_AW+2] == '0);
  assign uart_off = req_addr - UART_BASE;
  assign hit_uart = (uart_off < 32'd12);
  assign uart_reg = uart_off[3:2];

  assign ram_addr  = rst ? req_addr[RAM_AW+1:2] : '0;
  assign ram_wdata = rst ? req_wdata : '0;

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Count cycles spent waiting for the transmitter; restarts on every new TX access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == UART_TX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign tx_timeout = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tx_timeout = 1'b0;
`endif

  // State register plus the registered read data, TX byte and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rdata_q      <= '0;
      uart_tx_data <= '0;
      bus_err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      if (load_tx) begin
        uart_tx_data <= req_wdata[7:0];
      end
      if (set_err) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Next-state and output decode; RAM writes and unmapped writes complete in the IDLE cycle.
  always_comb begin
    state_nxt     = state;
    rdata_nxt     = rdata_q;
    stall         = 1'b0;
    rdata         = '0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    uart_tx_valid = 1'b0;
    uart_rx_ack   = 1'b0;
    load_tx       = 1'b0;
    set_err       = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          if (hit_ram) begin
            if (is_wr) begin
              ram_we = 1'b1;
            end else begin
              ram_re    = 1'b1;
              stall     = 1'b1;
              state_nxt = RAM_RD;
            end
          end else if (hit_uart) begin
            stall     = 1'b1;
            state_nxt = DONE;
            rdata_nxt = '0;
            if (is_wr) begin
              if (uart_reg == 2'd0) begin
                load_tx   = 1'b1;
                state_nxt = UART_TX;
              end
            end else if (is_rd) begin
              case (uart_reg)
                2'd1: rdata_nxt = {30'b0, uart_rx_valid, uart_tx_ready};
                2'd2: begin
                  if (uart_rx_valid) begin
                    rdata_nxt   = {24'b0, uart_rx_data};
                    uart_rx_ack = 1'b1;
                  end else begin
                    rdata_nxt = 32'hFFFF_FFFF;
                  end
                end
                default: rdata_nxt = '0;
              endcase
            end
          end else begin
            set_err = 1'b1;
            if (is_rd) begin
              stall     = 1'b1;
              rdata_nxt = '0;
              state_nxt = DONE;
            end
          end
        end
      end
      RAM_RD: begin
        rdata     = ram_rdata;
        state_nxt = IDLE;
      end
      UART_TX: begin
        uart_tx_valid = 1'b1;
        stall         = 1'b1;
        if (uart_tx_ready) begin
          state_nxt = DONE;
        end else if (tx_timeout) begin
          set_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        rdata     = rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
